// File: rtl/demux4_pkg.sv
// demux4_pkg: shared types and sizes for the demux4_buf slice.
// Sizes: SEL_W select bits, N_OUT channels, WIDTH default data width, CNT_W stats width.
package demux4_pkg;

  localparam int SEL_W = 2;
  localparam int N_OUT = 1 << SEL_W;
  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output buffer (EMPTY/FULL) with valid/ready drain side.
// Ports: clk, rst, enq, wdata, ready -> valid, data; cnt under DEMUX4_BUF_STATS_EN.
module demux_slot #(
  parameter int WIDTH = demux4_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
`ifdef DEMUX4_BUF_STATS_EN
  ,
  output logic [demux4_pkg::CNT_W-1:0] cnt
`endif
);
  import demux4_pkg::*;

  slot_state_t state;

  assign valid = (state == SLOT_FULL);

  // enq on a FULL slot only arrives while ready is high,
  // so it is a same-cycle replace: state stays FULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SLOT_EMPTY;
      data  <= '0;
    end else begin
      unique case (state)
        SLOT_EMPTY: begin
          if (enq) begin
            state <= SLOT_FULL;
            data  <= wdata;
          end
        end
        SLOT_FULL: begin
          if (enq) begin
            data <= wdata;
          end else if (ready) begin
            state <= SLOT_EMPTY;
          end
        end
        default: state <= SLOT_EMPTY;
      endcase
    end
  end

`ifdef DEMUX4_BUF_STATS_EN
  // Free-running dequeue count, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (valid && ready) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  // No dequeue counter in this build.
`endif

endmodule

// File: rtl/demux4_buf.sv
// demux4_buf: 1-to-4 buffered demux; in_sel steers in_data to one slot.
// Ports: in_valid/in_ready/in_data/in_sel, out_valid/out_ready/out_data; stat_cnt if DEMUX4_BUF_STATS_EN.
module demux4_buf #(
  parameter int WIDTH = demux4_pkg::WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [WIDTH-1:0]                         in_data,
  input  demux4_pkg::sel_t                         in_sel,
  output logic [demux4_pkg::N_OUT-1:0]             out_valid,
  input  logic [demux4_pkg::N_OUT-1:0]             out_ready,
  output logic [demux4_pkg::N_OUT-1:0][WIDTH-1:0]  out_data
`ifdef DEMUX4_BUF_STATS_EN
  ,
  output logic [demux4_pkg::N_OUT-1:0][demux4_pkg::CNT_W-1:0] stat_cnt
`endif
);
  import demux4_pkg::*;

  logic [N_OUT-1:0] enq;

  // Head-of-line: only the selected slot gates the input.
  assign in_ready = !out_valid[in_sel] || out_ready[in_sel];

  always_comb begin
    enq = '0;
    for (int i = 0; i < N_OUT; i++) begin
      enq[i] = in_valid && in_ready && (in_sel == sel_t'(i));
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk  (clk),
      .rst  (rst),
      .enq  (enq[g]),
      .wdata(in_data),
      .ready(out_ready[g]),
      .valid(out_valid[g]),
      .data (out_data[g])
`ifdef DEMUX4_BUF_STATS_EN
      ,
      .cnt  (stat_cnt[g])
`endif
    );
  end

endmodule

// File: tb/tb_demux4_buf.sv
// tb_demux4_buf: vector table plus scoreboard bench for demux4_buf.
// Runs the stats wrap sequence only when DEMUX4_BUF_STATS_EN is defined.
module tb_demux4_buf;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic [1:0]        in_sel;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [3:0][31:0]  out_data;
`ifdef DEMUX4_BUF_STATS_EN
  logic [3:0][15:0]  stat_cnt;
`endif

  always #5 clk = ~clk;

  demux4_buf #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef DEMUX4_BUF_STATS_EN
    ,
    .stat_cnt (stat_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] sb [4][$];
  int pops [4];

  typedef struct {
    logic        valid;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  ordy;
    logic        exp_ready;
    logic [3:0]  exp_valid;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] ev;
    #1;
    if (!rst) begin
      chk("in_ready_model", 128'(in_ready),
          128'((sb[in_sel].size() == 0) || out_ready[in_sel]));
      for (int ch = 0; ch < 4; ch++) begin
        if (out_valid[ch] && out_ready[ch]) begin
          if (sb[ch].size() == 0) begin
            chk("unexpected_pop", 128'(out_valid[ch]), 128'(0));
          end else begin
            chk("out_data_pop", 128'(out_data[ch]),
                128'(sb[ch].pop_front()));
          end
          pops[ch]++;
        end
      end
      if (in_valid && in_ready) sb[in_sel].push_back(in_data);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int ch = 0; ch < 4; ch++) begin
        sb[ch].delete();
        pops[ch] = 0;
      end
    end
    for (int ch = 0; ch < 4; ch++) ev[ch] = (sb[ch].size() != 0);
    chk("out_valid_model", 128'(out_valid), 128'(ev));
`ifdef DEMUX4_BUF_STATS_EN
    for (int ch = 0; ch < 4; ch++)
      chk("stat_cnt_model", 128'(stat_cnt[ch]), 128'(pops[ch][15:0]));
`endif
  endtask

  task automatic drive(input logic v, input logic [1:0] s,
                       input logic [31:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  initial begin
    int p0;
    vecs[0] = '{1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, 1'b1, 4'b0100};
    vecs[1] = '{1'b1, 2'd2, 32'h11111111, 4'b0000, 1'b0, 4'b0100};
    vecs[2] = '{1'b1, 2'd0, 32'h00000022, 4'b0000, 1'b1, 4'b0101};
    vecs[3] = '{1'b0, 2'd2, 32'h0000000F, 4'b0100, 1'b1, 4'b0001};
    vecs[4] = '{1'b1, 2'd0, 32'h00000033, 4'b0001, 1'b1, 4'b0001};
    vecs[5] = '{1'b1, 2'd3, 32'h00000044, 4'b0001, 1'b1, 4'b1000};
    vecs[6] = '{1'b0, 2'd0, 32'h00000055, 4'b1000, 1'b1, 4'b0000};
    for (int ch = 0; ch < 4; ch++) pops[ch] = 0;

    // Reset held two cycles with a word offered.
    rst = 1'b1;
    drive(1'b1, 2'd1, 32'hCAFE0001, 4'b0000);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_data", 128'(out_data), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));

    // Vector table.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].valid, vecs[i].sel, vecs[i].data, vecs[i].ordy);
      #1;
      chk($sformatf("vec%0d_in_ready", i), 128'(in_ready),
          128'(vecs[i].exp_ready));
      tick();
      chk($sformatf("vec%0d_out_valid", i), 128'(out_valid),
          128'(vecs[i].exp_valid));
    end
    chk("hold_data3", 128'(out_data[3]), 128'(32'h44));
    chk("hold_data2", 128'(out_data[2]), 128'(32'hDEADBEEF));
    chk("hold_data0", 128'(out_data[0]), 128'(32'h33));

    // Streaming into channel 1 at full rate.
    p0 = pops[1];
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 2'd1, 32'(i), 4'b0010);
      #1;
      chk("stream_in_ready", 128'(in_ready), 128'(1));
      tick();
    end
    drive(1'b0, 2'd1, 32'h0, 4'b0010);
    tick();
    chk("stream_count", 128'(pops[1] - p0), 128'(8));
    chk("stream_last", 128'(out_data[1]), 128'(32'h8));

    // Head-of-line blocking on channel 3.
    drive(1'b1, 2'd3, 32'h55, 4'b0000);
    tick();
    drive(1'b1, 2'd3, 32'h66, 4'b0000);
    #1;
    chk("hol_blocked", 128'(in_ready), 128'(0));
    tick();
    drive(1'b1, 2'd0, 32'h77, 4'b0000);
    #1;
    chk("hol_other", 128'(in_ready), 128'(1));
    tick();
    chk("hol_valid", 128'(out_valid), 128'(4'b1001));
    chk("hol_slot3", 128'(out_data[3]), 128'(32'h55));
    chk("hol_slot0", 128'(out_data[0]), 128'(32'h77));

    // Fill all four slots, then reset mid-operation.
    drive(1'b0, 2'd0, 32'h0, 4'b1111);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 32'hA0 + 32'(i), 4'b0000);
      tick();
    end
    chk("full_valid", 128'(out_valid), 128'(4'b1111));
    chk("full_data", 128'(out_data),
        {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    rst = 1'b1;
    drive(1'b1, 2'd2, 32'hBB, 4'b1111);
    tick();
    rst = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    #1;
    chk("mid_reset_valid", 128'(out_valid), 128'(0));
    chk("mid_reset_data", 128'(out_data), 128'(0));
`ifdef DEMUX4_BUF_STATS_EN
    chk("mid_reset_stats", 128'(stat_cnt), 128'(0));

    // 65537 dequeues on channel 0 wrap its counter to 1.
    for (int i = 0; i < 65537; i++) begin
      drive(1'b1, 2'd0, 32'(i), 4'b0001);
      tick();
    end
    drive(1'b0, 2'd0, 32'h0, 4'b0001);
    tick();
    chk("wrap_cnt0", 128'(stat_cnt[0]), 128'(16'd1));
    chk("wrap_others", 128'(stat_cnt[3:1]), 128'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
